regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Tracks in-flight register-file writes between instruction issue (ID→EX) and writeback (WB), and raises a stall when the instruction in ID reads a register whose producer has not yet written back. It is the producer-side counterpart of the WB→ID forwarding path: ID declares pending destinations, and WB (plus squash ports) retires them. It sits beside the ID stage, and its `stall` output feeds the hazard/stall control of the 5-stage rv32i pipeline.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending counter; max in-flight writes per register is 2^CNT_W−1.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rs1_num`  in  rv32i_reg  rs1 of the instruction in ID.
- `id_rs2_num`  in  rv32i_reg  rs2 of the instruction in ID.
- `id_rd_num`  in  rv32i_reg  rd of the instruction in ID.
- `ctrl_word`  in  rv32i_control_word  ID control word; uses `opcode` and `load_regfile`.
- `issue_valid`  in  1  the ID instruction advances to EX this cycle.
- `wb_retire_valid`  in  1  the WB instruction writes the regfile this cycle.
- `wb_rd_num`  in  rv32i_reg  WB destination.
- `kill0_valid`, `kill1_valid`  in  1  each: a squashed in-flight instruction that had issued with `load_regfile`.
- `kill0_rd`, `kill1_rd`  in  rv32i_reg  each: destination of the squashed instruction.
- `stall`  out  1  ID must hold this cycle.
- `busy_mask`  out  32  registered; bit r set when count[r] ≠ 0.
- `sb_overflow`  out  1  sticky error flag.
- `sb_underflow`  out  1  sticky error flag.

## Operation
- There is one CNT_W counter per register, 1..31. x0 is never tracked, and its busy bit is always 0.
- rs1 is used unless the opcode is op_lui, op_auipc or op_jal.
- rs2 is used only for op_reg, op_store and op_br.
- `rsN_busy` = used && rsN ≠ 0 && count[rsN] ≠ 0.
- `stall` = rs1_busy || rs2_busy.
- Effective issue = issue_valid && !stall && ctrl_word.load_regfile && id_rd_num ≠ 0. When asserted, it increments count[id_rd_num].
- Each of retire, kill0 and kill1 (with rd ≠ 0) decrements its register's counter.
- Next count[r] = count[r] + inc[r] − (number of decrements targeting r). All events in one cycle are summed, so issue and retire of the same rd leave the count unchanged.
- Two decrements to the same r in one cycle subtract 2.
- Saturation:
  - A result above 2^CNT_W−1 clamps to the maximum and sets `sb_overflow`.
  - A result below 0 clamps to 0 and sets `sb_underflow`.
  - Both flags are sticky until reset.
- `issue_valid` while `stall` is high is ignored; no count change.

## Timing
- Counter state, `busy_mask` and the error flags update on the rising edge of `clk`.
- `stall` is combinational from registered counts and the current ID inputs; there is zero added latency.
- Retire visibility:
  - A WB retire clears busy from the next cycle onward.
  - When forwarding in the same cycle is enabled (see Configuration), the clear is visible in the same cycle.
- Reset values on `rst_n` low, applied immediately: all counts 0, `busy_mask`=0, `stall`=0 (given x0 operands), `sb_overflow`=0, `sb_underflow`=0.
- Reset mid-operation discards all pending state. The pipeline is flushed by the same reset.

## Configuration
- `SCOREBOARD_WB_BYPASS_EN`, defined:
  - When wb_retire_valid && wb_rd_num == rsN, that operand is not busy in the same cycle, but only if count[rsN] == 1.
  - This relies on the WB→ID forwarding mux supplying the data.
- `SCOREBOARD_WB_BYPASS_EN`, undefined: busy depends only on registered counts, so each dependency costs one extra stall cycle.

## Structure
- Shared package rv32i_types (existing): rv32i_reg, rv32i_control_word, opcode enum.
- Add to rv32i_types: `SB_CNT_W` default constant, and function `uses_rs1(opcode)` / `uses_rs2(opcode)` so the forwarding units share the decode.
- One sub-module: `sb_counter`, a single saturating up/down counter with inc (1 bit), dec (0..3), and ovf/unf pulses. It is instantiated 31 times via generate.

## Test plan
- Reset, then ID op_reg x1,x2 with no issues → stall=0 and busy_mask=0; assert rst_n low mid-run with counts nonzero → all outputs 0 immediately.
- Issue add x5 (cycle 0); next ID addi using rs1=x5 → stall=1 until the WB retire of x5. Release timing:
  - macro off: stall drops the cycle after the retire.
  - macro on: stall drops in the retire cycle.
- op_imm in ID with rs2 field = x5 pending, rs1 = x0 → stall=0 (rs2 unused).
- Issue x7 three times, retiring none → count[7]=3; a fourth issue is blocked only if x7 is read. Force issue past saturation via a no-read instruction → sb_overflow=1 and count stays 3.
- Same-cycle issue of x9 and WB retire of x9 with count[9]=1 → count stays 1 and busy_mask[9]=1. kill0_rd=kill1_rd=x9 with count 2 → count 0.
- Retire x4 with count[4]=0 → sb_underflow=1 and count remains 0; issue with rd=x0 → busy_mask unchanged.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared rv32i pipeline types plus the register-scoreboard operand decode,
// so the scoreboard and the forwarding units agree on which operands are read.
package rv32i_types;

    typedef logic [4:0] rv32i_reg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        rv32i_opcode opcode;
        logic        load_regfile;
    } rv32i_control_word;

    localparam int unsigned SB_CNT_W = 2;

    function automatic logic uses_rs1(input rv32i_opcode op);
        return !(op == op_lui || op == op_auipc || op == op_jal);
    endfunction

    function automatic logic uses_rs2(input rv32i_opcode op);
        return (op == op_reg || op == op_store || op == op_br);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// One saturating pending-write counter: +inc, -dec (0..3) per cycle, with
// combinational overflow/underflow pulses for the parent's sticky flags.
module sb_counter
    import rv32i_types::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] count,
    output logic             busy_nxt_c,
    output logic             ovf_c,
    output logic             unf_c
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] MAX_CNT = SUM_W'((1 << CNT_W) - 1);

    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] nxt;

    // All events of the cycle are summed before clamping.
    always_comb begin
        up    = SUM_W'(count) + SUM_W'(inc);
        nxt   = '0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (SUM_W'(dec) > up) begin
            unf_c = 1'b1;
        end else begin
            nxt = up - SUM_W'(dec);
            if (nxt > MAX_CNT) begin
                nxt   = MAX_CNT;
                ovf_c = 1'b1;
            end
        end
    end

    assign busy_nxt_c = (nxt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= CNT_W'(nxt);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for x1..x31; stalls ID on reads of unretired producers.
// Optional SCOREBOARD_WB_BYPASS_EN: a same-cycle WB retire of the last pending write unblocks the read.
module regfile_scoreboard
    import rv32i_types::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  rv32i_reg          id_rs1_num,
    input  rv32i_reg          id_rs2_num,
    input  rv32i_reg          id_rd_num,
    input  rv32i_control_word ctrl_word,
    input  logic              issue_valid,
    input  logic              wb_retire_valid,
    input  rv32i_reg          wb_rd_num,
    input  logic              kill0_valid,
    input  rv32i_reg          kill0_rd,
    input  logic              kill1_valid,
    input  rv32i_reg          kill1_rd,
    output logic              stall,
    output logic [31:0]       busy_mask,
    output logic              sb_overflow,
    output logic              sb_underflow
);

    logic [CNT_W-1:0] cnt [32];
    logic [31:1]      busy_nxt;
    logic [31:1]      ovf_vec;
    logic [31:1]      unf_vec;
    logic             rs1_busy_c;
    logic             rs2_busy_c;
    logic             issue_eff_c;

    assign cnt[0] = '0;

    always_comb begin
        rs1_busy_c = uses_rs1(ctrl_word.opcode) && (id_rs1_num != '0) && (cnt[id_rs1_num] != '0);
        rs2_busy_c = uses_rs2(ctrl_word.opcode) && (id_rs2_num != '0) && (cnt[id_rs2_num] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Data for the last outstanding write arrives via the WB->ID forward.
        if (wb_retire_valid && (wb_rd_num == id_rs1_num) && (cnt[id_rs1_num] == CNT_W'(1))) begin
            rs1_busy_c = 1'b0;
        end
        if (wb_retire_valid && (wb_rd_num == id_rs2_num) && (cnt[id_rs2_num] == CNT_W'(1))) begin
            rs2_busy_c = 1'b0;
        end
`endif
    end

    assign stall       = rs1_busy_c || rs2_busy_c;
    assign issue_eff_c = issue_valid && !stall && ctrl_word.load_regfile && (id_rd_num != '0);

    for (genvar r = 1; r < 32; r++) begin : g_cnt
        logic       inc_r;
        logic [1:0] dec_r;

        assign inc_r = issue_eff_c && (id_rd_num == 5'(r));
        assign dec_r = 2'(wb_retire_valid && (wb_rd_num == 5'(r)))
                     + 2'(kill0_valid && (kill0_rd == 5'(r)))
                     + 2'(kill1_valid && (kill1_rd == 5'(r)));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .inc        (inc_r),
            .dec        (dec_r),
            .count      (cnt[r]),
            .busy_nxt_c (busy_nxt[r]),
            .ovf_c      (ovf_vec[r]),
            .unf_c      (unf_vec[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_mask    <= '0;
            sb_overflow  <= 1'b0;
            sb_underflow <= 1'b0;
        end else begin
            busy_mask    <= {busy_nxt, 1'b0};
            sb_overflow  <= sb_overflow  || (|ovf_vec);
            sb_underflow <= sb_underflow || (|unf_vec);
        end
    end

endmodule
